// File: rtl/circular_op_step_sequencer_pkg.sv
// Shared types and constants for the circular-interpolation step sequencer.
package circular_op_step_sequencer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CALC,
      ST_LOAD,
      ST_CHOOSE,
      ST_EMIT,
      ST_DONE
   } CircSeqState_t;

   typedef enum logic signed [1:0] {
      STEP_NEG  = 2'b11,
      STEP_NONE = 2'b00,
      STEP_POS  = 2'b01
   } StepDir_t;

   typedef enum logic [1:0] {
      QUAD_1,
      QUAD_2,
      QUAD_3,
      QUAD_4
   } quad_t;

   // Bit q set means the counter-clockwise candidate on that axis moves negative in quadrant q.
   localparam logic [3:0] QUAD_SX_NEG = 4'b0011;
   localparam logic [3:0] QUAD_SY_NEG = 4'b0110;

endpackage

// File: rtl/circular_op_step_sequencer_chooser.sv
// Combinational step picker: tries the X and Y candidate moves for the current
// quadrant and direction, keeping the one with the smaller radial error.
module circular_step_chooser
   import circular_op_step_sequencer_pkg::*;
#(
   parameter int NUM_BITS = 8,
   parameter int ERR_BITS = 2*NUM_BITS+2
) (
   input  logic signed [NUM_BITS-1:0] cur_x,
   input  logic signed [NUM_BITS-1:0] cur_y,
   input  logic signed [ERR_BITS-1:0] err,
   input  logic                       is_cw,
   output StepDir_t                   step_dx,
   output StepDir_t                   step_dy,
   output logic signed [ERR_BITS-1:0] next_err
);

   localparam logic signed [ERR_BITS-1:0] ONE = {{(ERR_BITS-1){1'b0}}, 1'b1};

   function automatic logic signed [ERR_BITS-1:0] sext(input logic signed [NUM_BITS-1:0] v);
      return {{(ERR_BITS-NUM_BITS){v[NUM_BITS-1]}}, v};
   endfunction

   function automatic logic [ERR_BITS-1:0] mag(input logic signed [ERR_BITS-1:0] v);
      return v[ERR_BITS-1] ? -v : v;
   endfunction

   quad_t quad;
   logic  x_pos, x_neg, x_zero, y_pos, y_neg, y_zero;
   logic  neg_x, neg_y;
   logic signed [ERR_BITS-1:0] two_x, two_y, ex, ey;

   always_comb begin
      x_zero = (cur_x == '0);
      y_zero = (cur_y == '0);
      x_neg  = cur_x[NUM_BITS-1];
      y_neg  = cur_y[NUM_BITS-1];
      x_pos  = !x_neg && !x_zero;
      y_pos  = !y_neg && !y_zero;

      if ((x_zero && y_zero) || (x_pos && !y_neg)) quad = QUAD_1;
      else if (!x_pos && y_pos)                     quad = QUAD_2;
      else if (x_neg && !y_pos)                     quad = QUAD_3;
      else                                          quad = QUAD_4;

      neg_x = QUAD_SX_NEG[quad] ^ is_cw;
      neg_y = QUAD_SY_NEG[quad] ^ is_cw;

      // Moving one unit changes x^2 by 2*x*s + 1.
      two_x = sext(cur_x) + sext(cur_x);
      two_y = sext(cur_y) + sext(cur_y);
      ex    = neg_x ? (err - two_x + ONE) : (err + two_x + ONE);
      ey    = neg_y ? (err - two_y + ONE) : (err + two_y + ONE);

      step_dx  = STEP_NONE;
      step_dy  = STEP_NONE;
      next_err = ex;
      if (mag(ex) <= mag(ey)) begin
         step_dx  = neg_x ? STEP_NEG : STEP_POS;
         next_err = ex;
      end else begin
         step_dy  = neg_y ? STEP_NEG : STEP_POS;
         next_err = ey;
      end
   end

endmodule

// File: rtl/circular_op_step_sequencer.sv
// Walks one circular-interpolation command as unit X/Y steps with valid/ready output.
// Optional build macro CIRCULAR_SEQ_END_CHECK_EN adds the end_mismatch output.
module circular_op_step_sequencer
   import circular_op_step_sequencer_pkg::*;
#(
   parameter int NUM_BITS  = 8,
   parameter int STEP_BITS = NUM_BITS+3,
   parameter int ERR_BITS  = 2*NUM_BITS+2
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        op_valid,
   output logic                        op_ready,
   input  logic                        is_cw,
   input  logic signed [NUM_BITS-1:0]  start_x,
   input  logic signed [NUM_BITS-1:0]  start_y,
   input  logic signed [NUM_BITS-1:0]  end_x,
   input  logic signed [NUM_BITS-1:0]  end_y,
   input  logic signed [NUM_BITS-1:0]  r,
   input  logic                        precise_crossing_axes,
   input  logic                        is_full_circle,
   output logic                        calc_is_cw,
   output logic signed [NUM_BITS-1:0]  calc_start_x,
   output logic signed [NUM_BITS-1:0]  calc_start_y,
   output logic signed [NUM_BITS-1:0]  calc_end_x,
   output logic signed [NUM_BITS-1:0]  calc_end_y,
   output logic signed [NUM_BITS-1:0]  calc_r,
   output logic                        calc_precise,
   output logic                        calc_full,
   input  logic        [STEP_BITS-1:0] calc_num_steps,
   output logic                        step_valid,
   input  logic                        step_ready,
   output logic signed [1:0]           step_dx,
   output logic signed [1:0]           step_dy,
   output logic                        busy,
   output logic                        done
`ifdef CIRCULAR_SEQ_END_CHECK_EN
   ,
   output logic                        end_mismatch
`endif
);

   localparam logic [STEP_BITS-1:0] ONE_STEP = {{(STEP_BITS-1){1'b0}}, 1'b1};

   function automatic logic signed [ERR_BITS-1:0] sq(input logic signed [NUM_BITS-1:0] v);
      logic signed [ERR_BITS-1:0] e;
      e = {{(ERR_BITS-NUM_BITS){v[NUM_BITS-1]}}, v};
      return e * e;
   endfunction

   function automatic logic signed [NUM_BITS-1:0] step_ext(input logic signed [1:0] d);
      return {{(NUM_BITS-2){d[1]}}, d};
   endfunction

   CircSeqState_t state_q, state_d;
   logic signed [NUM_BITS-1:0]  cur_x, cur_y;
   logic signed [ERR_BITS-1:0]  err_q, next_err_q, ch_err;
   logic        [STEP_BITS-1:0] remaining;
   StepDir_t                    ch_dx, ch_dy;

   circular_step_chooser #(.NUM_BITS(NUM_BITS), .ERR_BITS(ERR_BITS)) u_chooser (
      .cur_x    (cur_x),
      .cur_y    (cur_y),
      .err      (err_q),
      .is_cw    (calc_is_cw),
      .step_dx  (ch_dx),
      .step_dy  (ch_dy),
      .next_err (ch_err)
   );

   always_ff @(posedge clk) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (op_valid) state_d = ST_CALC;
         ST_CALC:   state_d = ST_LOAD;
         ST_LOAD:   state_d = (calc_num_steps == '0) ? ST_DONE : ST_CHOOSE;
         ST_CHOOSE: state_d = ST_EMIT;
         ST_EMIT:   if (step_ready) state_d = (remaining > ONE_STEP) ? ST_CHOOSE : ST_DONE;
         ST_DONE:   state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   assign op_ready   = (state_q == ST_IDLE);
   assign busy       = (state_q != ST_IDLE);
   assign step_valid = (state_q == ST_EMIT);
   assign done       = (state_q == ST_DONE);

   always_ff @(posedge clk) begin
      if (reset) begin
         calc_is_cw   <= 1'b0;
         calc_start_x <= '0;
         calc_start_y <= '0;
         calc_end_x   <= '0;
         calc_end_y   <= '0;
         calc_r       <= '0;
         calc_precise <= 1'b0;
         calc_full    <= 1'b0;
         step_dx      <= '0;
         step_dy      <= '0;
      end else begin
         if (state_q == ST_IDLE && op_valid) begin
            calc_is_cw   <= is_cw;
            calc_start_x <= start_x;
            calc_start_y <= start_y;
            calc_end_x   <= end_x;
            calc_end_y   <= end_y;
            calc_r       <= r;
            calc_precise <= precise_crossing_axes;
            calc_full    <= is_full_circle;
         end
         if (state_q == ST_CHOOSE) begin
            step_dx <= ch_dx;
            step_dy <= ch_dy;
         end
      end
   end

   // Arc walk datapath; only meaningful while the FSM is busy, so no reset.
   always_ff @(posedge clk) begin
      case (state_q)
         ST_IDLE: begin
            if (op_valid) begin
               cur_x <= start_x;
               cur_y <= start_y;
            end
         end
         ST_LOAD: begin
            remaining <= calc_num_steps;
            err_q     <= sq(cur_x) + sq(cur_y) - sq(calc_r);
         end
         ST_CHOOSE: next_err_q <= ch_err;
         ST_EMIT: begin
            if (step_ready) begin
               cur_x     <= cur_x + step_ext(step_dx);
               cur_y     <= cur_y + step_ext(step_dy);
               err_q     <= next_err_q;
               remaining <= remaining - ONE_STEP;
            end
         end
         default: ;
      endcase
   end

`ifdef CIRCULAR_SEQ_END_CHECK_EN
   logic end_diff, mismatch_q;
   assign end_diff = (cur_x != calc_end_x) || (cur_y != calc_end_y);

   always_ff @(posedge clk) begin
      if (reset)                              mismatch_q <= 1'b0;
      else if (state_q == ST_IDLE && op_valid) mismatch_q <= 1'b0;
      else if (state_q == ST_DONE)            mismatch_q <= end_diff;
   end

   assign end_mismatch = (state_q == ST_DONE) ? end_diff : mismatch_q;
`endif

endmodule

// File: tb/tb_circular_op_step_sequencer.sv
// Self-checking bench for circular_op_step_sequencer against a direct radial-error model.
module tb_circular_op_step_sequencer;

   localparam int NUM_BITS  = 8;
   localparam int STEP_BITS = NUM_BITS+3;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic op_valid = 1'b0, op_ready, is_cw = 1'b0;
   logic signed [NUM_BITS-1:0] start_x = '0, start_y = '0, end_x = '0, end_y = '0, r = '0;
   logic precise_crossing_axes = 1'b0, is_full_circle = 1'b0;
   logic calc_is_cw, calc_precise, calc_full;
   logic signed [NUM_BITS-1:0] calc_start_x, calc_start_y, calc_end_x, calc_end_y, calc_r;
   logic [STEP_BITS-1:0] calc_num_steps = '0;
   logic step_valid, step_ready = 1'b1, busy, done;
   logic signed [1:0] step_dx, step_dy;
`ifdef CIRCULAR_SEQ_END_CHECK_EN
   logic end_mismatch;
`endif

   circular_op_step_sequencer dut (
      .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready), .is_cw(is_cw),
      .start_x(start_x), .start_y(start_y), .end_x(end_x), .end_y(end_y), .r(r),
      .precise_crossing_axes(precise_crossing_axes), .is_full_circle(is_full_circle),
      .calc_is_cw(calc_is_cw), .calc_start_x(calc_start_x), .calc_start_y(calc_start_y),
      .calc_end_x(calc_end_x), .calc_end_y(calc_end_y), .calc_r(calc_r),
      .calc_precise(calc_precise), .calc_full(calc_full), .calc_num_steps(calc_num_steps),
      .step_valid(step_valid), .step_ready(step_ready), .step_dx(step_dx), .step_dy(step_dy),
      .busy(busy), .done(done)
`ifdef CIRCULAR_SEQ_END_CHECK_EN
      , .end_mismatch(end_mismatch)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int tests = 0, fails = 0;
   int exp_dx[$], exp_dy[$];
   int mod_x, mod_y, pos_x, pos_y;
   int cnt_xn, cnt_xp, cnt_yn, cnt_yp;

   task automatic check(input string tag, input int obs, input int exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int iabs(input int v);
      return (v < 0) ? -v : v;
   endfunction

   // Each step: pick the quadrant's candidate move whose new point lies closest to the circle.
   task automatic model(input int cw, input int x0, input int y0, input int rr, input int n);
      int x, y, cx, cy, ex, ey;
      x = x0; y = y0;
      exp_dx.delete(); exp_dy.delete();
      for (int i = 0; i < n; i++) begin
         if ((x == 0 && y == 0) || (x > 0 && y >= 0)) begin cx = -1; cy =  1; end
         else if (x <= 0 && y > 0)                   begin cx = -1; cy = -1; end
         else if (x < 0 && y <= 0)                   begin cx =  1; cy = -1; end
         else                                        begin cx =  1; cy =  1; end
         if (cw != 0) begin cx = -cx; cy = -cy; end
         ex = (x+cx)*(x+cx) + y*y - rr*rr;
         ey = x*x + (y+cy)*(y+cy) - rr*rr;
         if (iabs(ex) <= iabs(ey)) begin exp_dx.push_back(cx); exp_dy.push_back(0); x += cx; end
         else                      begin exp_dx.push_back(0); exp_dy.push_back(cy); y += cy; end
      end
      mod_x = x; mod_y = y;
   endtask

   // mode: 0 ready always high, 1 five-cycle stall on the 2nd step, 2 random ready
   task automatic run_cmd(input string tag, input int cw, input int sx, input int sy,
                          input int ex, input int ey, input int rr, input int n,
                          input int full, input int mode, input int check_end);
      int c_acc, first_v, done_c, stalls, idx, bp, dx, dy;
      bit got_done, rdy;
      model(cw, sx, sy, rr, n);
      pos_x = sx; pos_y = sy;
      cnt_xn = 0; cnt_xp = 0; cnt_yn = 0; cnt_yp = 0;
      first_v = -1; done_c = -1; stalls = 0; idx = 0; bp = 0; got_done = 0;
      @(negedge clk);
      check({tag, "/op_ready_idle"}, int'(op_ready), 1);
      is_cw = cw[0]; start_x = NUM_BITS'(sx); start_y = NUM_BITS'(sy);
      end_x = NUM_BITS'(ex); end_y = NUM_BITS'(ey); r = NUM_BITS'(rr);
      is_full_circle = full[0]; precise_crossing_axes = ~full[0];
      calc_num_steps = STEP_BITS'(n); step_ready = 1'b1; op_valid = 1'b1;
      c_acc = cyc + 1;
      @(negedge clk);
      op_valid = 1'b0;
      check({tag, "/calc_r"}, int'(calc_r), rr);
      check({tag, "/calc_start"}, int'(calc_start_x)*256 + int'(calc_start_y), sx*256 + sy);
      check({tag, "/calc_end"}, int'(calc_end_x)*256 + int'(calc_end_y), ex*256 + ey);
      check({tag, "/calc_flags"}, {calc_is_cw, calc_full, calc_precise}, {cw[0], full[0], ~full[0]});
      check({tag, "/busy"}, {busy, op_ready}, 2'b10);
      for (int k = 0; k < 6*n + 60 && !got_done; k++) begin
         if (done) begin
            got_done = 1; done_c = cyc;
`ifdef CIRCULAR_SEQ_END_CHECK_EN
            check({tag, "/end_mismatch"}, int'(end_mismatch), int'(mod_x != ex || mod_y != ey));
`endif
         end else begin
            if (step_valid) begin
               if (first_v < 0) first_v = cyc;
               dx = int'(step_dx); dy = int'(step_dy);
               case (mode)
                  1:       rdy = !(idx == 1 && bp < 5);
                  2:       rdy = ($urandom_range(0, 3) != 0);
                  default: rdy = 1'b1;
               endcase
               if (!rdy) begin
                  stalls++;
                  if (idx < n) check({tag, "/stall_hold"}, dx*4 + dy, exp_dx[idx]*4 + exp_dy[idx]);
                  if (mode == 1) begin
                     if (bp > 0) begin
                        check({tag, "/busy_op_ready"}, int'(op_ready), 0);
                        check({tag, "/busy_calc_r"}, int'(calc_r), rr);
                     end
                     bp++;
                     r = NUM_BITS'(rr + 1); op_valid = 1'b1;
                  end
               end else begin
                  op_valid = 1'b0; r = NUM_BITS'(rr);
                  if (idx < n) check({tag, "/step"}, dx*4 + dy, exp_dx[idx]*4 + exp_dy[idx]);
                  else         check({tag, "/extra_step"}, idx, n - 1);
                  check({tag, "/one_axis"}, int'(dx != 0) + int'(dy != 0), 1);
                  pos_x += dx; pos_y += dy;
                  if (dx < 0) cnt_xn++;
                  if (dx > 0) cnt_xp++;
                  if (dy < 0) cnt_yn++;
                  if (dy > 0) cnt_yp++;
                  if (full != 0)
                     check({tag, "/radial"}, int'(iabs(pos_x*pos_x + pos_y*pos_y - rr*rr) <= 5), 1);
                  idx++;
               end
               step_ready = rdy;
            end else begin
               step_ready = 1'b1;
            end
            @(negedge clk);
         end
      end
      op_valid = 1'b0;
      check({tag, "/done_seen"}, int'(got_done), 1);
      check({tag, "/step_count"}, idx, n);
      check({tag, "/done_cycle"}, done_c, c_acc + 2 + 2*n + stalls);
      check({tag, "/first_valid"}, first_v, (n > 0) ? c_acc + 3 : -1);
      check({tag, "/final_pos"}, pos_x*256 + pos_y, mod_x*256 + mod_y);
      if (check_end != 0) check({tag, "/end_pos"}, pos_x*256 + pos_y, ex*256 + ey);
      @(negedge clk);
      check({tag, "/after_done"}, {done, op_ready, busy, step_valid}, 4'b0100);
`ifdef CIRCULAR_SEQ_END_CHECK_EN
      check({tag, "/end_mismatch_hold"}, int'(end_mismatch), int'(mod_x != ex || mod_y != ey));
`endif
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: observed timeout required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int rr, q, sx, sy, n, seen;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      check("reset/ctrl", {op_ready, step_valid, busy, done}, 4'b1000);
      check("reset/dir", int'(step_dx)*4 + int'(step_dy), 0);
      check("reset/calc", int'(calc_r) + int'(calc_start_x) + int'(calc_end_y) + int'(calc_is_cw) + int'(calc_full), 0);
      reset = 1'b0;

      run_cmd("quarter_ccw", 0, 4, 0, 0, 4, 4, 8, 0, 0, 1);
      check("quarter_ccw/dx_neg", cnt_xn, 4);
      check("quarter_ccw/dy_pos", cnt_yp, 4);

      run_cmd("full_circle", 0, 3, 0, 3, 0, 3, 24, 1, 0, 1);
      run_cmd("backpressure", 0, 4, 0, 0, 4, 4, 8, 0, 1, 1);
      run_cmd("zero_steps", 0, 4, 0, 0, 4, 4, 0, 0, 0, 0);

      // Abort a command while a step is being offered.
      @(negedge clk);
      is_cw = 1'b0; start_x = 8'sd4; start_y = 8'sd0; end_x = 8'sd0; end_y = 8'sd4; r = 8'sd4;
      calc_num_steps = STEP_BITS'(8); step_ready = 1'b0; op_valid = 1'b1;
      @(negedge clk);
      op_valid = 1'b0;
      seen = 0;
      for (int k = 0; k < 10 && seen == 0; k++) begin
         if (step_valid) seen = 1;
         else @(negedge clk);
      end
      check("reset_emit/valid_seen", seen, 1);
      reset = 1'b1;
      @(negedge clk);
      check("reset_emit/abort", {step_valid, busy, op_ready, done}, 4'b0010);
      reset = 1'b0; step_ready = 1'b1;
      @(negedge clk);
      check("reset_emit/no_done", {done, op_ready}, 2'b01);
      run_cmd("after_reset", 0, 4, 0, 0, 4, 4, 8, 0, 0, 1);

      run_cmd("quarter_cw", 1, 0, 4, 4, 0, 4, 8, 0, 0, 1);
      check("quarter_cw/dx_pos", cnt_xp, 4);
      check("quarter_cw/dy_neg", cnt_yn, 4);

      for (int t = 0; t < 6; t++) begin
         rr = $urandom_range(1, 15);
         q  = $urandom_range(0, 3);
         sx = (q == 0) ? rr : (q == 2) ? -rr : 0;
         sy = (q == 1) ? rr : (q == 3) ? -rr : 0;
         n  = $urandom_range(0, 8*rr);
         run_cmd("random", $urandom_range(0, 1), sx, sy, sx, sy, rr, n, 0, 2, 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
